// File: rtl/button_reader.sv
// button_reader: cleans up active-low push buttons into debounced levels and event pulses.
// Each channel has a 2-flop synchroniser, a debounce filter, press/release pulses,
// long-press detection and auto-repeat pulses. All outputs are registered on i_clk.
// Ports:
//   i_clk      system clock
//   i_rst      synchronous reset, active-high
//   i_btn_n    raw asynchronous button pins, 0 = pressed
//   o_level    debounced state, 1 = pressed
//   o_press    1-cycle pulse when o_level rises
//   o_release  1-cycle pulse when o_level falls
//   o_long     1-cycle pulse LONG_CYCLES after o_press while still held
//   o_repeat   1-cycle pulse at long-press and every REPEAT_CYCLES after while held
module button_reader #(
   parameter int unsigned N_BUTTONS       = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 270000,
   parameter int unsigned LONG_CYCLES     = 27000000,
   parameter int unsigned REPEAT_CYCLES   = 5400000
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [N_BUTTONS-1:0] i_btn_n,
   output logic [N_BUTTONS-1:0] o_level,
   output logic [N_BUTTONS-1:0] o_press,
   output logic [N_BUTTONS-1:0] o_release,
   output logic [N_BUTTONS-1:0] o_long,
   output logic [N_BUTTONS-1:0] o_repeat
);

   localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int unsigned HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int unsigned HW   = $clog2(HMAX) + 1;

   typedef enum logic [1:0] {
      ST_RELEASED = 2'd0,
      ST_PRESSED  = 2'd1,
      ST_LONG     = 2'd2
   } state_t;

   for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
      logic          sync1, sync2;
      logic          s_btn;
      logic [CW-1:0] cnt, cnt_nxt;
      logic          level, level_nxt;
      state_t        state, state_nxt;
      logic [HW-1:0] hcnt, hcnt_nxt;
      logic          press_q, release_q, long_q, repeat_q;
      logic          press_nxt, release_nxt, long_nxt, repeat_nxt;
      logic          rise_c, fall_c;

      assign s_btn = ~sync2;

      // State register: synchroniser, debounce, FSM and output pulse flops.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            cnt       <= '0;
            level     <= 1'b0;
            state     <= ST_RELEASED;
            hcnt      <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
         end else begin
            sync1     <= i_btn_n[g];
            sync2     <= sync1;
            cnt       <= cnt_nxt;
            level     <= level_nxt;
            state     <= state_nxt;
            hcnt      <= hcnt_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            long_q    <= long_nxt;
            repeat_q  <= repeat_nxt;
         end
      end

      // Next-state: debounce filter, edge pulses and hold/repeat FSM.
      always_comb begin
         cnt_nxt     = '0;
         level_nxt   = level;
         state_nxt   = state;
         hcnt_nxt    = '0;
         press_nxt   = 1'b0;
         release_nxt = 1'b0;
         long_nxt    = 1'b0;
         repeat_nxt  = 1'b0;
         rise_c      = 1'b0;
         fall_c      = 1'b0;

         // Counter only runs while the synchronised input disagrees with the level.
         if (s_btn != level) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               level_nxt = ~level;
               rise_c    = ~level;
               fall_c    = level;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end

         press_nxt   = rise_c;
         release_nxt = fall_c;

         case (state)
            ST_RELEASED: begin
               if (rise_c) begin
                  state_nxt = ST_PRESSED;
               end
            end
            ST_PRESSED: begin
               if (hcnt == HW'(LONG_CYCLES - 1)) begin
                  state_nxt  = ST_LONG;
                  long_nxt   = 1'b1;
                  repeat_nxt = 1'b1;
               end else begin
                  hcnt_nxt = hcnt + HW'(1);
               end
            end
            ST_LONG: begin
               if (hcnt == HW'(REPEAT_CYCLES - 1)) begin
                  repeat_nxt = 1'b1;
               end else begin
                  hcnt_nxt = hcnt + HW'(1);
               end
            end
            default: state_nxt = ST_RELEASED;
         endcase

         // A release wins over a long/repeat landing on the same edge.
         if (fall_c) begin
            state_nxt  = ST_RELEASED;
            hcnt_nxt   = '0;
            long_nxt   = 1'b0;
            repeat_nxt = 1'b0;
         end
      end

      assign o_level[g]   = level;
      assign o_press[g]   = press_q;
      assign o_release[g] = release_q;
      assign o_long[g]    = long_q;
      assign o_repeat[g]  = repeat_q;
   end

endmodule
